fp_add_arbiter: RTL

Round-robin arbiter and sequencer that shares one pipelined IEEE-754 single-precision adder (`IEEE_SP_FP_ADDER`) among N requesters in the matrix-multiplier datapath, such as the row accumulators. It accepts one operand pair per cycle from the winning requester and drives the adder's operand inputs. It tracks each issued operation's owner through the adder pipeline and returns every sum to its owner on a shared result bus with a one-hot valid.

---
 rtl/fp_add_arbiter_if.sv | 27 ++
 rtl/fp_add_arbiter.sv | 91 +++++++++
 2 files changed

// File: rtl/fp_add_arbiter_if.sv
// Bundle of requester, adder and response signals shared by the arbiter.
// master: requesters plus the adder (the environment); slave: the arbiter.
interface fp_add_arbiter_if #(
    parameter int N = 4
);
    logic            hold;
    logic [N-1:0]    req_valid;
    logic [32*N-1:0] req_a;
    logic [32*N-1:0] req_b;
    logic [N-1:0]    req_ready;
    logic [31:0]     add_a;
    logic [31:0]     add_b;
    logic [31:0]     add_result;
    logic [N-1:0]    resp_valid;
    logic [31:0]     resp_data;
    logic            busy;

    modport master (
        output hold, req_valid, req_a, req_b, add_result,
        input  req_ready, add_a, add_b, resp_valid, resp_data, busy
    );

    modport slave (
        input  hold, req_valid, req_a, req_b, add_result,
        output req_ready, add_a, add_b, resp_valid, resp_data, busy
    );
endinterface

// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one pipelined FP adder among N requesters.
// A tag pipeline (valid + owner) runs alongside the adder so each sum is
// returned to the requester that issued it, in issue order.
module fp_add_arbiter #(
    parameter int N   = 4,
    parameter int LAT = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    fp_add_arbiter_if.slave bus
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic          grant_vld;
    logic [PW-1:0] grant_idx;
    logic [N-1:0]  req_ready_d;
    logic [31:0]   add_a_q, add_a_d;
    logic [31:0]   add_b_q, add_b_d;
    logic [LAT:0]  tag_v_q;
    logic [PW-1:0] tag_own_q [LAT+1];
    logic [N-1:0]  resp_valid_q, resp_valid_d;
    logic [31:0]   resp_data_q, resp_data_d;

    // Scan requesters starting at the round-robin pointer; first valid wins.
    always_comb begin
        int idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        if (!rst_i && !bus.hold) begin
            for (int k = 0; k < N; k++) begin
                idx = int'(ptr_q) + k;
                if (idx >= N) idx = idx - N;
                if (!grant_vld && bus.req_valid[idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = PW'(idx);
                end
            end
        end
    end

    // Next-state: one-hot grant/response decode, pointer advance, operand mux.
    always_comb begin
        req_ready_d  = '0;
        resp_valid_d = '0;
        for (int i = 0; i < N; i++) begin
            req_ready_d[i]  = grant_vld && (grant_idx == PW'(i));
            resp_valid_d[i] = tag_v_q[LAT] && (tag_own_q[LAT] == PW'(i));
        end
        ptr_d   = ptr_q;
        add_a_d = '0;
        add_b_d = '0;
        if (grant_vld) begin
            ptr_d   = (grant_idx == PW'(N - 1)) ? '0 : grant_idx + PW'(1);
            add_a_d = bus.req_a[32*grant_idx +: 32];
            add_b_d = bus.req_b[32*grant_idx +: 32];
        end
        // Sum is held between responses so the bus stays quiet.
        resp_data_d = tag_v_q[LAT] ? bus.add_result : resp_data_q;
    end

    // State registers; reset discards every in-flight tag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q        <= '0;
            add_a_q      <= '0;
            add_b_q      <= '0;
            tag_v_q      <= '0;
            for (int s = 0; s <= LAT; s++) tag_own_q[s] <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
        end else begin
            ptr_q        <= ptr_d;
            add_a_q      <= add_a_d;
            add_b_q      <= add_b_d;
            tag_v_q      <= {tag_v_q[LAT-1:0], grant_vld};
            tag_own_q[0] <= grant_idx;
            for (int s = 1; s <= LAT; s++) tag_own_q[s] <= tag_own_q[s-1];
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign bus.req_ready  = req_ready_d;
    assign bus.add_a      = add_a_q;
    assign bus.add_b      = add_b_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.busy       = (|tag_v_q) | (|resp_valid_q);
endmodule
